serial_addsub: RTL

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/serial_addsub_fa.sv | 16 +
 rtl/serial_addsub.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding and the default operand width.
package serial_addsub_pkg;

    localparam int unsigned SERIAL_ADDSUB_DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub_fa.sv
// Single-bit full-adder cell used by the serial adder datapath.
module FA (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Sum and majority carry of three input bits.
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands are loaded into shift registers and
// one bit per cycle is summed LSB-first through a single full-adder cell.
// Subtraction adds ~B with a carry-in of 1.
// Optional macro SERIAL_ADDSUB_OVF_EN compiles in signed-overflow detection;
// without it ovf_out is tied low.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned DATA_W = SERIAL_ADDSUB_DATA_W_DEFAULT
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              op_valid_in,
    output logic              op_ready_out,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] B_in,
    input  logic              sub_in,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic [DATA_W-1:0] S_out,
    output logic              C_out,
    output logic              ovf_out
);

    localparam int unsigned         CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(DATA_W - 1);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sum_bit;
    logic               cout_bit;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic               cmsb_q, cmsb_d;
`endif

    FA u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (sum_bit),
        .c_o (cout_bit)
    );

    // State and datapath registers; reset clears everything and returns to IDLE.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
            cmsb_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            cmsb_q  <= cmsb_d;
`endif
        end
    end

    // Next-state and datapath update: load in IDLE, one bit per RUN cycle,
    // hold in DONE until the result is taken.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        cmsb_d  = cmsb_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (op_valid_in) begin
                    a_d     = A_in;
                    b_d     = sub_in ? ~B_in : B_in;
                    carry_d = sub_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {sum_bit, res_q[DATA_W-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = cout_bit;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
`ifdef SERIAL_ADDSUB_OVF_EN
                    // carry_q here is the carry into the MSB cell
                    cmsb_d  = carry_q;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake and result outputs come straight from registered state.
    always_comb begin
        op_ready_out  = (state_q == IDLE);
        res_valid_out = (state_q == DONE);
        S_out         = res_q;
        C_out         = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_out       = cmsb_q ^ carry_q;
`else
        ovf_out       = 1'b0;
`endif
    end

endmodule
